song_player: RTL and testbench

- Playback-side counterpart of the key/recording controller: reads stored note entries from song memory and renders them on the buzzer.
- Fetches one entry per note over a simple req/valid read port, starting at a selected base address.
- Generates a square wave at the note's pitch for the note's duration, followed by a short silent articulation gap.
- Stops on an end marker, on address wrap, or on an external stop. It sits between the song memory and the buzzer/display mux.

---
 rtl/song_player.sv | 229 ++++++++++++++++++++++
 tb/tb_song_player.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_player.sv
// song_player: plays note entries fetched from song memory as a square wave.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start, stop            - begin playback at song_base / abort playback
//   song_base              - first entry address, captured when start is accepted
//   mem_rd, mem_addr       - read request and address toward song memory
//   mem_valid, mem_data    - read response: [8]=end [7:6]=oct [5:3]=note [2:0]=len
//   buzzer                 - square-wave output (0 during rests and gaps)
//   playing                - high whenever the player is not idle
//   cur_note, cur_octave   - note being sounded, 0 outside PLAY
//   done                   - one-cycle pulse on natural song end
module song_player #(
    parameter int ADDR_W      = 6,
    parameter int TICK_CYCLES = 100000,
    parameter int DIV_SHIFT   = 0,
    parameter int GAP_MS      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] song_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [8:0]        mem_data,
    output logic              buzzer,
    output logic              playing,
    output logic [2:0]        cur_note,
    output logic [1:0]        cur_octave,
    output logic              done
);

    localparam int TW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int MS_W = 16;
    localparam int HP_W = 20;

    localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [MS_W-1:0] GAP_LAST  = MS_W'(GAP_MS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PLAY,
        GAP,
        FINISH
    } state_t;

    state_t              r_state;
    logic                r_mem_rd;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic                r_buzzer;
    logic [2:0]          r_cur_note;
    logic [1:0]          r_cur_oct;
    logic                r_done;

    // Entry fields held for the whole note
    logic [2:0]          r_note;
    logic [1:0]          r_oct;
    logic [2:0]          r_len;

    logic [TW-1:0]       r_tick;
    logic [MS_W-1:0]     r_ms;
    logic [HP_W-1:0]     r_hcnt;

    logic [HP_W-1:0]     w_base;
    logic [HP_W-1:0]     w_scaled;
    logic [HP_W-1:0]     w_half_raw;
    logic [HP_W-1:0]     w_half;
    logic [MS_W-1:0]     w_dur_ms;

    // Half-period of each note at octave 1, in clk cycles
    always_comb begin
        case (r_note)
            3'd1:    w_base = HP_W'(190840);
            3'd2:    w_base = HP_W'(170068);
            3'd3:    w_base = HP_W'(151515);
            3'd4:    w_base = HP_W'(143266);
            3'd5:    w_base = HP_W'(127551);
            3'd6:    w_base = HP_W'(113636);
            3'd7:    w_base = HP_W'(101215);
            default: w_base = HP_W'(0);
        endcase
    end

    // Octave 3 has no table entry of its own and reuses octave 2
    always_comb begin
        case (r_oct)
            2'd0:    w_scaled = w_base << 1;
            2'd1:    w_scaled = w_base;
            default: w_scaled = w_base >> 1;
        endcase
    end

    assign w_half_raw = w_scaled >> DIV_SHIFT;
    // A large DIV_SHIFT could zero the period; keep the divider sane
    assign w_half     = (w_half_raw == '0) ? HP_W'(1) : w_half_raw;

    // 125 ms doubled per length step, saturating at 2 s
    assign w_dur_ms   = (r_len > 3'd4) ? MS_W'(2000)
                                       : (MS_W'(125) << r_len);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_buzzer   <= 1'b0;
            r_cur_note <= 3'd0;
            r_cur_oct  <= 2'd0;
            r_done     <= 1'b0;
            r_note     <= 3'd0;
            r_oct      <= 2'd0;
            r_len      <= 3'd0;
            r_tick     <= '0;
            r_ms       <= '0;
            r_hcnt     <= '0;
        end else if (stop && (r_state != IDLE)) begin
            r_state    <= IDLE;
            r_mem_rd   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_cur_note <= 3'd0;
            r_cur_oct  <= 2'd0;
            r_done     <= 1'b0;
            r_tick     <= '0;
            r_ms       <= '0;
            r_hcnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_mem_addr <= song_base;
                        r_mem_rd   <= 1'b1;
                        r_state    <= FETCH;
                    end
                end

                FETCH: begin
                    if (mem_valid) begin
                        r_mem_rd <= 1'b0;
                        r_note   <= mem_data[5:3];
                        r_oct    <= mem_data[7:6];
                        r_len    <= mem_data[2:0];
                        if (mem_data[8]) begin
                            r_done  <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_tick     <= '0;
                            r_ms       <= '0;
                            r_hcnt     <= '0;
                            r_buzzer   <= 1'b0;
                            r_cur_note <= mem_data[5:3];
                            r_cur_oct  <= mem_data[7:6];
                            r_state    <= PLAY;
                        end
                    end
                end

                PLAY: begin
                    if (r_hcnt == w_half - HP_W'(1)) begin
                        r_hcnt <= '0;
                        if (r_note != 3'd0) begin
                            r_buzzer <= ~r_buzzer;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + HP_W'(1);
                    end

                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_ms == w_dur_ms - MS_W'(1)) begin
                            // Later assignments override the toggle above
                            r_ms       <= '0;
                            r_hcnt     <= '0;
                            r_buzzer   <= 1'b0;
                            r_cur_note <= 3'd0;
                            r_cur_oct  <= 2'd0;
                            r_state    <= GAP;
                        end else begin
                            r_ms <= r_ms + MS_W'(1);
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end

                GAP: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick <= '0;
                        if (r_ms == GAP_LAST) begin
                            r_ms <= '0;
                            // Last address ends the song instead of wrapping
                            if (&r_mem_addr) begin
                                r_done  <= 1'b1;
                                r_state <= FINISH;
                            end else begin
                                r_mem_addr <= r_mem_addr + ADDR_W'(1);
                                r_mem_rd   <= 1'b1;
                                r_state    <= FETCH;
                            end
                        end else begin
                            r_ms <= r_ms + MS_W'(1);
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end

                FINISH: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd     = r_mem_rd;
    assign mem_addr   = r_mem_addr;
    assign buzzer     = r_buzzer;
    assign playing    = (r_state != IDLE);
    assign cur_note   = r_cur_note;
    assign cur_octave = r_cur_oct;
    assign done       = r_done;

endmodule

// File: tb/tb_song_player.sv
// tb_song_player: directed scenarios for song_player
// (TICK_CYCLES=10, DIV_SHIFT=10, GAP_MS=2).
module tb_song_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [5:0] song_base;
    logic       mem_rd;
    logic [5:0] mem_addr;
    logic       mem_valid = 1'b0;
    logic [8:0] mem_data = 9'h1ff;
    logic       buzzer;
    logic       playing;
    logic [2:0] cur_note;
    logic [1:0] cur_octave;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mem [0:63];
    logic [5:0] rd_q [$];
    int mem_delay = 0;
    int wait_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    song_player #(
        .ADDR_W(6),
        .TICK_CYCLES(10),
        .DIV_SHIFT(10),
        .GAP_MS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .song_base(song_base),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_valid(mem_valid),
        .mem_data(mem_data),
        .buzzer(buzzer),
        .playing(playing),
        .cur_note(cur_note),
        .cur_octave(cur_octave),
        .done(done)
    );

    // Memory model: answers mem_rd after mem_delay waiting cycles.
    // While not valid it drives an end marker so early capture is visible.
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (mem_rd === 1'b1) begin
            if (wait_cnt >= mem_delay) begin
                mem_valid = 1'b1;
                mem_data  = mem[mem_addr];
                wait_cnt  = 0;
                rd_q.push_back(mem_addr);
            end else begin
                mem_valid = 1'b0;
                mem_data  = 9'h100;
                wait_cnt++;
            end
        end else begin
            mem_valid = 1'b0;
            mem_data  = 9'h1ff;
            wait_cnt  = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [5:0] base);
        song_base = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int w);
        w = 0;
        while (playing !== 1'b0 && w < max) begin
            tick();
            w++;
        end
    endtask

    // Measures one sounding note: length, first toggle, toggle count,
    // whether all intervals match the first, and the starting buzzer level.
    task automatic measure_note(input int max, output int len,
                                output int first, output int ntog,
                                output bit uni, output logic [2:0] note,
                                output logic [1:0] oct, output logic b0);
        int w;
        int idx;
        int last;
        logic pb;
        w = 0; len = 0; first = 0; ntog = 0; uni = 1'b1;
        note = 3'd0; oct = 2'd0; b0 = 1'bx; last = 0;
        while (cur_note === 3'd0 && w < 200) begin
            tick();
            w++;
        end
        if (cur_note === 3'd0) return;
        note = cur_note;
        oct  = cur_octave;
        b0   = buzzer;
        pb   = buzzer;
        idx  = 0;
        while (cur_note !== 3'd0 && idx < max) begin
            if (buzzer !== pb) begin
                if (ntog == 0) first = idx;
                else if (idx - last != first) uni = 1'b0;
                ntog++;
                last = idx;
                pb = buzzer;
            end
            idx++;
            tick();
        end
        len = idx;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; song_base = 6'd0;
        repeat (3) tick();
        n_cmp++;
        if ({mem_rd, mem_addr, buzzer, playing, cur_note, cur_octave, done} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want all 0",
                     {mem_rd, mem_addr, buzzer, playing, cur_note, cur_octave, done});
        end
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (playing !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: playing got %b want 0", playing);
        end
    endtask

    task automatic test_basic_note();
        int len, first, ntog, g, w, d0;
        bit uni;
        logic [2:0] nt;
        logic [1:0] oc;
        logic b0;
        mem[0] = 9'h070;
        mem[1] = 9'h100;
        rd_q.delete();
        d0 = done_cnt;
        pulse_start(6'd0);
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 6'd0) begin
            n_bad++;
            $display("FAIL basic_fetch: rd=%b addr=%0d want rd=1 addr=0", mem_rd, mem_addr);
        end
        measure_note(3000, len, first, ntog, uni, nt, oc, b0);
        n_cmp++;
        if (len !== 1250) begin
            n_bad++;
            $display("FAIL basic_len: got %0d want 1250", len);
        end
        n_cmp++;
        if (nt !== 3'd6 || oc !== 2'd1) begin
            n_bad++;
            $display("FAIL basic_note: got note %0d oct %0d want 6/1", nt, oc);
        end
        n_cmp++;
        if (b0 !== 1'b0 || first !== 110 || ntog !== 11 || uni !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_wave: b0=%b first=%0d ntog=%0d uni=%0d want 0/110/11/1",
                     b0, first, ntog, uni);
        end
        g = 0;
        while (mem_rd !== 1'b1 && g < 100) begin
            g++;
            tick();
        end
        n_cmp++;
        if (g !== 20 || mem_addr !== 6'd1) begin
            n_bad++;
            $display("FAIL basic_gap: got %0d cycles addr %0d want 20 addr 1", g, mem_addr);
        end
        wait_idle(50, w);
        n_cmp++;
        if (playing !== 1'b0 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL basic_done: playing=%b done pulses=%0d want 0/1",
                     playing, done_cnt - d0);
        end
        n_cmp++;
        if (rd_q.size() !== 2 || (rd_q.size() == 2 && rd_q[1] !== 6'd1)) begin
            n_bad++;
            $display("FAIL basic_reads: got %0d reads want 2 (0,1)", rd_q.size());
        end
    endtask

    task automatic test_fetch_wait();
        int n, bad, d0;
        mem[0] = 9'h070;
        mem[1] = 9'h100;
        mem_delay = 5;
        d0 = done_cnt;
        start = 1'b1; song_base = 6'd0;
        tick();
        start = 1'b0;
        n = 0; bad = 0;
        while (mem_valid !== 1'b1 && n < 20) begin
            if (mem_rd !== 1'b1 || mem_addr !== 6'd0) bad++;
            n++;
            tick();
        end
        n_cmp++;
        if (n !== 5 || bad !== 0) begin
            n_bad++;
            $display("FAIL wait_hold: wait=%0d unstable=%0d want 5/0", n, bad);
        end
        n_cmp++;
        if (mem_rd !== 1'b1) begin
            n_bad++;
            $display("FAIL wait_rd_on_valid: got %b want 1", mem_rd);
        end
        tick();
        n_cmp++;
        if (mem_rd !== 1'b0 || cur_note !== 3'd6 || done_cnt !== d0) begin
            n_bad++;
            $display("FAIL wait_capture: rd=%b note=%0d done=%0d want 0/6/0",
                     mem_rd, cur_note, done_cnt - d0);
        end
        mem_delay = 0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic test_octaves();
        int len, first, ntog, w, d0;
        bit uni;
        logic [2:0] nt;
        logic [1:0] oc;
        logic b0;
        mem[0] = 9'h089;
        mem[1] = 9'h00f;
        mem[2] = 9'h100;
        d0 = done_cnt;
        pulse_start(6'd0);
        measure_note(5000, len, first, ntog, uni, nt, oc, b0);
        n_cmp++;
        if (len !== 2500 || nt !== 3'd1 || oc !== 2'd2) begin
            n_bad++;
            $display("FAIL oct2_note: len=%0d note=%0d oct=%0d want 2500/1/2", len, nt, oc);
        end
        n_cmp++;
        if (first !== 93 || ntog !== 26 || uni !== 1'b1) begin
            n_bad++;
            $display("FAIL oct2_wave: first=%0d ntog=%0d uni=%0d want 93/26/1",
                     first, ntog, uni);
        end
        measure_note(25000, len, first, ntog, uni, nt, oc, b0);
        n_cmp++;
        if (len !== 20000 || nt !== 3'd1 || oc !== 2'd0) begin
            n_bad++;
            $display("FAIL oct0_note: len=%0d note=%0d oct=%0d want 20000/1/0", len, nt, oc);
        end
        n_cmp++;
        if (b0 !== 1'b0 || first !== 372 || ntog !== 53 || uni !== 1'b1) begin
            n_bad++;
            $display("FAIL oct0_wave: b0=%b first=%0d ntog=%0d uni=%0d want 0/372/53/1",
                     b0, first, ntog, uni);
        end
        wait_idle(100, w);
        n_cmp++;
        if (playing !== 1'b0 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL oct_done: playing=%b pulses=%0d want 0/1", playing, done_cnt - d0);
        end
    endtask

    task automatic test_rest();
        int n, bad, w, d0;
        mem[0] = 9'h042;
        mem[1] = 9'h100;
        d0 = done_cnt;
        pulse_start(6'd0);
        tick();
        n = 0; bad = 0;
        while (mem_rd !== 1'b1 && n < 6000) begin
            if (buzzer !== 1'b0 || playing !== 1'b1 || cur_note !== 3'd0) bad++;
            n++;
            tick();
        end
        n_cmp++;
        if (n !== 5020 || bad !== 0) begin
            n_bad++;
            $display("FAIL rest_window: cycles=%0d bad=%0d want 5020/0", n, bad);
        end
        wait_idle(50, w);
        n_cmp++;
        if (playing !== 1'b0 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL rest_done: playing=%b pulses=%0d want 0/1", playing, done_cnt - d0);
        end
    endtask

    task automatic test_stop();
        int w, d0;
        mem[0] = 9'h070;
        mem[1] = 9'h100;
        d0 = done_cnt;
        pulse_start(6'd0);
        w = 0;
        while (cur_note === 3'd0 && w < 20) begin
            tick();
            w++;
        end
        repeat (150) tick();
        n_cmp++;
        if (buzzer !== 1'b1) begin
            n_bad++;
            $display("FAIL stop_pre_buzzer: got %b want 1", buzzer);
        end
        start = 1'b1; song_base = 6'd9;
        tick();
        start = 1'b0;
        n_cmp++;
        if (mem_rd !== 1'b0 || mem_addr !== 6'd0 || cur_note !== 3'd6) begin
            n_bad++;
            $display("FAIL start_ignored: rd=%b addr=%0d note=%0d want 0/0/6",
                     mem_rd, mem_addr, cur_note);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if ({playing, buzzer, mem_rd, cur_note, cur_octave} !== 8'd0) begin
            n_bad++;
            $display("FAIL stop_abort: got %b want all 0",
                     {playing, buzzer, mem_rd, cur_note, cur_octave});
        end
        repeat (30) tick();
        n_cmp++;
        if (done_cnt !== d0 || playing !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_no_done: pulses=%0d playing=%b want 0/0",
                     done_cnt - d0, playing);
        end
        start = 1'b1; stop = 1'b1;
        tick();
        n_cmp++;
        if (playing !== 1'b0 || mem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL start_stop_same: playing=%b rd=%b want 0/0", playing, mem_rd);
        end
        start = 1'b0; stop = 1'b0;
        tick();
    endtask

    task automatic test_wrap_reset();
        int w, d0, first_rd;
        mem[63] = 9'h078;
        mem[0]  = 9'h070;
        rd_q.delete();
        d0 = done_cnt;
        pulse_start(6'd63);
        wait_idle(3000, w);
        first_rd = (rd_q.size() > 0) ? int'(rd_q[0]) : -1;
        n_cmp++;
        if (rd_q.size() !== 1 || first_rd !== 63 || mem_addr !== 6'd63) begin
            n_bad++;
            $display("FAIL wrap_reads: n=%0d first=%0d addr=%0d want 1/63/63",
                     rd_q.size(), first_rd, mem_addr);
        end
        n_cmp++;
        if (playing !== 1'b0 || done_cnt - d0 !== 1) begin
            n_bad++;
            $display("FAIL wrap_done: playing=%b pulses=%0d want 0/1", playing, done_cnt - d0);
        end
        d0 = done_cnt;
        pulse_start(6'd63);
        w = 0;
        while (cur_note === 3'd0 && w < 20) begin
            tick();
            w++;
        end
        repeat (100) tick();
        n_cmp++;
        if (buzzer !== 1'b1 || cur_note !== 3'd7) begin
            n_bad++;
            $display("FAIL rst_pre: buzzer=%b note=%0d want 1/7", buzzer, cur_note);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({mem_rd, mem_addr, buzzer, playing, cur_note, cur_octave, done} !== 15'd0) begin
            n_bad++;
            $display("FAIL rst_mid_play: got %b want all 0",
                     {mem_rd, mem_addr, buzzer, playing, cur_note, cur_octave, done});
        end
        rst_n = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (playing !== 1'b0 || done_cnt !== d0) begin
            n_bad++;
            $display("FAIL rst_after: playing=%b pulses=%0d want 0/0", playing, done_cnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 9'h100;
        test_reset();
        test_basic_note();
        test_fetch_wait();
        test_octaves();
        test_rest();
        test_stop();
        test_wrap_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
